// File: rtl/seq_mult_unit_if.sv
// rtl/seq_mult_unit_if.sv - start/busy/done operand and result bundle for seq_mult_unit
interface seq_mult_unit_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic [WIDTH-1:0]       data_in;
    logic                   busy;
    logic                   done;
    logic                   eqz;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  eqz,
        input  product
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output eqz,
        output product
    );
endinterface

// File: rtl/seq_mult_unit.sv
// rtl/seq_mult_unit.sv - repeated-addition unsigned multiplier, A then B on a shared bus
// Optional operand swap (fewest iterations) under MULT_SWAP_EN.
module seq_mult_unit #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mult_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LDB  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   p_q;
    logic                 busy_q;
    logic                 done_q;

    logic [WIDTH-1:0]     a_load_d;
    logic [WIDTH-1:0]     b_load_d;
    logic [WIDTH-1:0]     b_dec_d;
    logic [2*WIDTH-1:0]   p_sum_d;
    logic                 eqz;

    assign eqz     = (b_q == '0);
    assign b_dec_d = b_q - 1'b1;
    // At most 2^WIDTH-1 additions of a WIDTH-bit value, so 2*WIDTH bits never wrap.
    assign p_sum_d = p_q + {{WIDTH{1'b0}}, a_q};

`ifdef MULT_SWAP_EN
    logic swap;
    // Keep the smaller operand in the counter so the loop runs min(A,B) times.
    assign swap     = (bus.data_in > a_q);
    assign a_load_d = swap ? bus.data_in : a_q;
    assign b_load_d = swap ? a_q : bus.data_in;
`else
    assign a_load_d = a_q;
    assign b_load_d = bus.data_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.data_in;
                        busy_q  <= 1'b1;
                        state_q <= S_LDB;
                    end
                end
                S_LDB: begin
                    a_q     <= a_load_d;
                    b_q     <= b_load_d;
                    p_q     <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (eqz) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        p_q <= p_sum_d;
                        b_q <= b_dec_d;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.eqz     = eqz;
    assign bus.product = p_q;
endmodule

// File: tb/tb_seq_mult_unit.sv
// tb/tb_seq_mult_unit.sv - directed self-checking bench for seq_mult_unit
module tb_seq_mult_unit;
    localparam int W = 16;

`ifdef MULT_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seq_mult_unit_if #(.WIDTH(W)) bus ();

    seq_mult_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in cycle 0 (start already driven); returns in the done cycle.
    task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] exp_p, input int exp_cyc,
                             input int inj_cyc, input bit chk_steps, input string tag);
        int cyc;
        int busy_bad;
        int k;
        @(posedge clk); #1;
        cyc = 1;
        bus.start   = 1'b0;
        bus.data_in = b;
        check({tag, " ldb busy"}, 64'(bus.busy), 64'd1);
        busy_bad = 0;
        while (bus.done !== 1'b1 && cyc < exp_cyc + 10) begin
            @(posedge clk); #1;
            cyc++;
            bus.start   = (cyc == inj_cyc);
            bus.data_in = (cyc == inj_cyc) ? 16'd2 : b;
            if (bus.done !== 1'b1) begin
                if (bus.busy !== 1'b1) busy_bad++;
                if (chk_steps) begin
                    k = cyc - 2;
                    if (k > exp_cyc - 3) k = exp_cyc - 3;
                    check($sformatf("%s step c%0d", tag, cyc), 64'(bus.product),
                          64'(a) * 64'(k));
                end
            end
        end
        bus.start = 1'b0;
        check({tag, " done seen"}, 64'(bus.done), 64'd1);
        check({tag, " done cycle"}, 64'(cyc), 64'(exp_cyc));
        check({tag, " product"}, 64'(bus.product), 64'(exp_p));
        check({tag, " busy gaps"}, 64'(busy_bad), 64'd0);
        check({tag, " busy at done"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_p, input int exp_cyc, input string tag);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.data_in = a;
        finish_op(a, b, exp_p, exp_cyc, -1, 1'b0, tag);
    endtask

    initial begin
        int done_seen;
        bus.start   = 1'b0;
        bus.data_in = '0;
        rst_n       = 1'b1;
        #2 rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst product", 64'(bus.product), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst eqz", 64'(bus.eqz), 64'd1);

        // First edge after reset release accepts start.
        rst_n       = 1'b1;
        bus.start   = 1'b1;
        bus.data_in = 16'd7;
        finish_op(16'd7, 16'd5, 32'd35, 8, -1, 1'b1, "7x5");
        @(posedge clk); #1;
        check("7x5 done one cycle", 64'(bus.done), 64'd0);
        check("7x5 product hold", 64'(bus.product), 64'd35);

        do_op(16'd9, 16'd0, 32'd0, 3, "9x0");
        do_op(16'd0, 16'd4, 32'd0, SWAP ? 3 : 7, "0x4");
        do_op(16'd3, 16'd1000, 32'd3000, SWAP ? 6 : 1003, "3x1000");
        do_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 65538, "max");

        // Start pulsed mid-RUN, then start raised in the DONE cycle.
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.data_in = 16'd4;
        finish_op(16'd4, 16'd6, 32'd24, SWAP ? 7 : 9, 4, 1'b0, "4x6 busy");
        bus.start   = 1'b1;
        bus.data_in = 16'd3;
        @(posedge clk); #1;
        check("start at done ignored", 64'(bus.busy), 64'd0);
        check("4x6 product after done", 64'(bus.product), 64'd24);
        finish_op(16'd3, 16'd5, 32'd15, SWAP ? 6 : 8, -1, 1'b0, "b2b 3x5");

        // Reset in cycle 4 of 10x10.
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.data_in = 16'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("10x10 pre-reset product", 64'(bus.product), 64'd20);
        rst_n = 1'b0;
        #1;
        check("mid rst product", 64'(bus.product), 64'd0);
        check("mid rst busy", 64'(bus.busy), 64'd0);
        check("mid rst eqz", 64'(bus.eqz), 64'd1);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) done_seen++;
        end
        check("mid rst no done", 64'(done_seen), 64'd0);
        rst_n = 1'b1;
        do_op(16'd2, 16'd3, 32'd6, SWAP ? 5 : 6, "2x3 after rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
